// File: rtl/apes_cdc_pkg.sv
// Shared definitions for the APES clock-domain-crossing blocks.
// Holds the handshake FSM encoding and the default per-phase timeout.
package apes_cdc_pkg;

  localparam int unsigned DefaultTimeout = 1023;

  typedef enum logic [1:0] {
    StIdle,
    StReqHi,
    StReqLo,
    StErr
  } tx_state_e;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so the synchronizer can match the source's idle level.
module sync2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      q      <= ResetVal;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmit side of a 4-phase req/ack handshake towards an asynchronous receiver.
// Holds data_out stable for the whole handshake and flags a sticky error on phase timeout.
module cdc_handshake_tx
  import apes_cdc_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ack_async,
  input  logic              clr_err,
  output logic              ready,
  output logic              req,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              err
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int unsigned    CntW       = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  tx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            ack_s;
  logic            timeout_hit;

  sync2ff #(
    .ResetVal (1'b0)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_async),
    .q     (ack_s)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);
  assign ready       = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      req      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if ((state_q == StReqHi || state_q == StReqLo) && cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Every transition below also clears the phase counter; the ack checks
      // come first so an ack edge beats a simultaneous timeout.
      unique case (state_q)
        StIdle: begin
          if (send) begin
            data_out <= data_in;
            req      <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StReqHi;
          end
        end
        StReqHi: begin
          if (ack_s) begin
            req     <= 1'b0;
            cnt_q   <= '0;
            state_q <= StReqLo;
          end else if (timeout_hit) begin
            req     <= 1'b0;
            err     <= 1'b1;
            cnt_q   <= '0;
            state_q <= StErr;
          end
        end
        StReqLo: begin
          if (!ack_s) begin
            done    <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (timeout_hit) begin
            err     <= 1'b1;
            cnt_q   <= '0;
            state_q <= StErr;
          end
        end
        StErr: begin
          if (clr_err && !ack_s) begin
            err     <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          req     <= 1'b0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: accepted words are queued at send time and
// checked against data_out on each done pulse; an inline receiver drives ack_async.
module tb_cdc_handshake_tx;

  localparam int unsigned Tmo = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [15:0] data_in = '0;
  logic        ack_async = 1'b0;
  logic        clr_err = 1'b0;
  logic        ready;
  logic        req;
  logic [15:0] data_out;
  logic        done;
  logic        err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  logic        done_prev = 1'b0;
  logic [15:0] sb[$];

  cdc_handshake_tx #(
    .DATA_W  (16),
    .TIMEOUT (Tmo)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send      (send),
    .data_in   (data_in),
    .ack_async (ack_async),
    .clr_err   (clr_err),
    .ready     (ready),
    .req       (req),
    .data_out  (data_out),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic val, input int budget);
    for (int i = 0; i < budget && req !== val; i++) @(negedge clk);
    if (req !== val) check("wait_req", {31'd0, req}, {31'd0, val});
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && ready !== 1'b1; i++) @(negedge clk);
    if (ready !== 1'b1) check("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic wait_err(input int budget);
    for (int i = 0; i < budget && err !== 1'b1; i++) @(negedge clk);
    if (err !== 1'b1) check("wait_err", {31'd0, err}, 32'd1);
  endtask

  // Receiver side: raise ack dh cycles after req rises, drop it dl cycles after req falls.
  task automatic handshake(input logic [15:0] d, input int dh, input int dl, input int off);
    wait_req(1'b1, 5);
    check("dout_hi", {16'd0, data_out}, {16'd0, d});
    repeat (dh) @(posedge clk);
    #(off) ack_async = 1'b1;
    wait_req(1'b0, 12);
    repeat (dl) @(posedge clk);
    #(off) ack_async = 1'b0;
    wait_ready(12);
    @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] d, input int dh, input int dl, input int off);
    @(negedge clk);
    send    = 1'b1;
    data_in = d;
    sb.push_back(d);
    @(posedge clk);
    #1;
    send    = 1'b0;
    data_in = 16'($urandom);
    handshake(d, dh, dl, off);
  endtask

  task automatic start_no_ack(input logic [15:0] d);
    @(negedge clk);
    send    = 1'b1;
    data_in = d;
    sb.push_back(d);
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  task automatic drop_pending();
    check("sb_pending", sb.size(), 1);
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("done_len", {31'd0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [15:0] exp_d;
        exp_d = sb.pop_front();
        check("dout_done", {16'd0, data_out}, {16'd0, exp_d});
      end
      n_done++;
    end
    done_prev = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int hi;

    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dout", {16'd0, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transfer, receiver responds 3 cycles each way.
    d0 = n_done;
    xfer(16'hA5C3, 3, 3, 2);
    check("basic_done", n_done - d0, 1);
    check("basic_ready", {31'd0, ready}, 32'd1);

    // Back-pressure: send held high, data_in changes mid-handshake.
    d0 = n_done;
    @(negedge clk);
    send    = 1'b1;
    data_in = 16'hA5C3;
    sb.push_back(16'hA5C3);
    wait_req(1'b1, 5);
    check("bp_dout_hi", {16'd0, data_out}, 32'h0000A5C3);
    repeat (2) @(negedge clk);
    data_in = 16'h1234;
    sb.push_back(16'h1234);
    @(posedge clk);
    #3 ack_async = 1'b1;
    wait_req(1'b0, 12);
    check("bp_dout_lo", {16'd0, data_out}, 32'h0000A5C3);
    @(posedge clk);
    #3 ack_async = 1'b0;
    wait_ready(12);
    check("bp_dout_idle", {16'd0, data_out}, 32'h0000A5C3);
    @(posedge clk);
    #1;
    send = 1'b0;
    check("bp_next_dout", {16'd0, data_out}, 32'h00001234);
    check("bp_next_ready", {31'd0, ready}, 32'd0);
    handshake(16'h1234, 1, 1, 4);
    check("bp_done", n_done - d0, 2);

    // Timeout with no ack: req stays high while the counter runs 0..Tmo.
    d0 = n_done;
    start_no_ack(16'hBEEF);
    wait_req(1'b1, 5);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req) hi++;
      else break;
    end
    check("tmo_req_cycles", hi, Tmo + 1);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_ready", {31'd0, ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("tmo_sticky", {31'd0, err}, 32'd1);
    drop_pending();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("tmo_clr_err", {31'd0, err}, 32'd0);
    check("tmo_clr_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    check("tmo_no_done", n_done - d0, 0);

    // clr_err in IDLE does nothing.
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("idle_clr_ready", {31'd0, ready}, 32'd1);
    check("idle_clr_err", {31'd0, err}, 32'd0);

    // Stuck ack: clr_err cannot leave ERR while ack is high.
    d0 = n_done;
    start_no_ack(16'hCAFE);
    wait_err(20);
    drop_pending();
    @(negedge clk);
    ack_async = 1'b1;
    repeat (3) @(posedge clk);
    #1 clr_err = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stuck_err", {31'd0, err}, 32'd1);
    check("stuck_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    ack_async = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stuck_hold", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    check("stuck_release", {31'd0, ready}, 32'd1);
    check("stuck_err_clr", {31'd0, err}, 32'd0);
    clr_err = 1'b0;
    @(negedge clk);
    check("stuck_no_done", n_done - d0, 0);

    // Reset in REQ_HI aborts the transfer asynchronously.
    d0 = n_done;
    start_no_ack(16'h0F0F);
    wait_req(1'b1, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, req}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_dout", {16'd0, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drop_pending();
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", n_done - d0, 0);

    // Random data and receiver timing at random sub-cycle offsets.
    d0 = n_done;
    for (int i = 0; i < 1000; i++) begin
      xfer(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(1, 9)));
    end
    check("rnd_done", n_done - d0, 1000);
    check("sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter DATA_W SHALL be: default 16; width of the transferred word.
REQ-002 Parameter TIMEOUT SHALL be: default 1023; clk cycles allowed per handshake phase; 0 disables the timeout.
REQ-003 clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 send  input  1  request to transfer data_in; accepted only when ready=1.
REQ-006 data_in  input  DATA_W  word to transfer; sampled on an accepted send.
REQ-007 ack_async  input  1  acknowledge from the asynchronous receiver; no phase relation to clk.
REQ-008 clr_err  input  1  clears the sticky error and allows recovery from ERR.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 req  output  1  4-phase request to the receiver; registered and glitch-free.
REQ-011 data_out  output  DATA_W  registered word; held stable from req rise until synchronized ack falls.
REQ-012 done  output  1  one-cycle pulse on handshake completion.
REQ-013 err  output  1  sticky timeout flag.

Function
REQ-014 The block SHALL synchronize ack_async through two rising-edge flops (reset value 0) before use; the result is ack_s.
REQ-015 The FSM SHALL have four states: IDLE, REQ_HI, REQ_LO, and ERR.
REQ-016 IDLE: on send=1, data_in SHALL be captured into data_out, req SHALL be 1 on the next cycle, and the FSM SHALL go to REQ_HI.
REQ-017 REQ_HI: req=1; on ack_s=1, req SHALL be 0 on the next cycle and the FSM SHALL go to REQ_LO.
REQ-018 REQ_LO: req=0; on ack_s=0, done SHALL pulse for one cycle and the FSM SHALL go to IDLE, with ready=1 in the following cycle.
REQ-019 send while ready=0 SHALL be ignored; data_out SHALL NOT change outside an accepted send.
REQ-020 The phase counter SHALL clear on every state change, increment each cycle in REQ_HI and REQ_LO, and be $clog2(TIMEOUT+1) bits wide, saturating.
REQ-021 If the counter reaches TIMEOUT with TIMEOUT>0 in REQ_HI or REQ_LO, the FSM SHALL go to ERR, drive req=0, and set err=1.
REQ-022 If the ack edge and the timeout occur in the same cycle, the ack transition SHALL win.
REQ-023 ERR: the FSM SHALL return to IDLE only when clr_err=1 and ack_s=0 in the same cycle; err SHALL clear on that cycle, and no done pulse SHALL be emitted.
REQ-024 clr_err outside ERR SHALL have no effect.
REQ-025 Minimum send-to-done latency SHALL be 1 cycle (req rise) + 2 cycles (ack sync) + 1 cycle (req fall) + 2 cycles (ack sync) + 1 cycle, plus the receiver's response time.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, req=0, done=0, err=0, data_out=0, counter=0, sync flops=0.
REQ-027 ready SHALL be 1 while reset is asserted and after reset.
REQ-028 Reset asserted mid-handshake SHALL abort the transfer with no done pulse; req drops immediately.

Structure
REQ-029 The state encoding and the default TIMEOUT constant SHALL reside in the shared package apes_cdc_pkg.
REQ-030 The ack synchronizer SHALL be a separate sub-module, sync2ff (1 bit, reset value parameterized to 0), instantiated once.
REQ-031 All outputs SHALL be driven directly from flops, except ready, which is decoded from the state register.

Verification
REQ-032 Basic: send with data_in=16'hA5C3; receiver acks 3 cycles after req and releases ack 3 cycles after req falls -> data_out=A5C3 while req=1, exactly one done pulse, ready returns to 1.
REQ-033 Back-pressure: send held at 1 across a transfer with data_in changing to 16'h1234 mid-handshake -> data_out remains A5C3 until done; 1234 is accepted only in the next IDLE cycle.
REQ-034 Timeout: TIMEOUT=8, ack never rises -> req falls and err=1 at count 8; clr_err=1 with ack=0 -> IDLE, err=0, no done pulse.
REQ-035 Stuck ack: in ERR, ack_async=1 and clr_err=1 -> state remains ERR; dropping ack -> returns to IDLE 3 cycles later.
REQ-036 Reset mid-handshake: rst_n pulsed low in REQ_HI -> req=0 and ready=1 asynchronously, no done pulse.
REQ-037 Asynchronous ack: ack_async toggled at random sub-cycle offsets over 1000 transfers -> no lost or duplicated done pulses, and data_out matches the sequence of accepted data.
